// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gating controller: per-bank RUN/IDLE_WAIT/GATED/WAKE FSMs
// driving registered ICG enables, plus a saturating count of gating events.
module clk_gate_ctrl #(
  parameter int unsigned N_DOM    = 4,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DOM-1:0] act,
  input  logic             force_on,
  input  logic [7:0]       idle_thr,
  input  logic             stat_clr,
  output logic [N_DOM-1:0] clk_en,
  output logic [N_DOM-1:0] rdy,
  output logic [N_DOM-1:0] gated,
  output logic [15:0]      gate_events
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  localparam logic [3:0] WAKE_L = 4'(WAKE_CYC);
  localparam logic [4:0] WAKE_X = 5'(WAKE_CYC);

  state_e           state_q [N_DOM];
  state_e           state_d [N_DOM];
  logic [7:0]       icnt_q  [N_DOM];
  logic [7:0]       icnt_d  [N_DOM];
  logic [3:0]       wcnt_q  [N_DOM];
  logic [3:0]       wcnt_d  [N_DOM];
  logic [N_DOM-1:0] idle_s;
  logic [N_DOM-1:0] enter_s;
  logic [N_DOM-1:0] clk_en_q, clk_en_d;
  logic [N_DOM-1:0] rdy_q, rdy_d;
  logic [N_DOM-1:0] gated_q, gated_d;
  logic [4:0]       n_enter_s;
  logic [16:0]      ev_sum_s;
  logic [15:0]      gate_events_q, gate_events_d;

  assign idle_s = ~act & {N_DOM{~force_on & (idle_thr != 8'd0)}};

  // Per-bank next state, counters and the flop-bound output decode
  always_comb begin
    clk_en_d = {N_DOM{1'b1}};
    rdy_d    = {N_DOM{1'b1}};
    gated_d  = {N_DOM{1'b0}};
    enter_s  = {N_DOM{1'b0}};
    for (int i = 0; i < N_DOM; i++) begin
      state_d[i] = state_q[i];
      icnt_d[i]  = icnt_q[i];
      wcnt_d[i]  = wcnt_q[i];
      case (state_q[i])
        ST_RUN: begin
          if (idle_s[i]) begin
            if (idle_thr == 8'd1) begin
              state_d[i] = ST_GATED;
              icnt_d[i]  = 8'd0;
              enter_s[i] = 1'b1;
            end else begin
              state_d[i] = ST_IDLE;
              icnt_d[i]  = 8'd1;
            end
          end else begin
            icnt_d[i] = 8'd0;
          end
        end
        ST_IDLE: begin
          if (!idle_s[i]) begin
            state_d[i] = ST_RUN;
            icnt_d[i]  = 8'd0;
          end else if (({1'b0, icnt_q[i]} + 9'd1) >= {1'b0, idle_thr}) begin
            // threshold is re-read every cycle, so a lowered value gates at once
            state_d[i] = ST_GATED;
            icnt_d[i]  = 8'd0;
            enter_s[i] = 1'b1;
          end else begin
            icnt_d[i] = icnt_q[i] + 8'd1;
          end
        end
        ST_GATED: begin
          if (act[i] || force_on) begin
            wcnt_d[i]  = 4'd0;
            state_d[i] = (WAKE_L == 4'd0) ? ST_RUN : ST_WAKE;
          end else begin
            state_d[i] = ST_GATED;
          end
        end
        ST_WAKE: begin
          if (({1'b0, wcnt_q[i]} + 5'd1) == WAKE_X) begin
            state_d[i] = ST_RUN;
            wcnt_d[i]  = 4'd0;
          end else begin
            wcnt_d[i] = wcnt_q[i] + 4'd1;
          end
        end
        default: begin
          state_d[i] = ST_RUN;
          icnt_d[i]  = 8'd0;
          wcnt_d[i]  = 4'd0;
        end
      endcase
      clk_en_d[i] = (state_d[i] != ST_GATED);
      rdy_d[i]    = (state_d[i] == ST_RUN) || (state_d[i] == ST_IDLE);
      gated_d[i]  = (state_d[i] == ST_GATED);
    end
  end

  // Population count of banks entering GATED and the saturating accumulate
  always_comb begin
    n_enter_s = 5'd0;
    for (int i = 0; i < N_DOM; i++) begin
      n_enter_s = n_enter_s + {4'd0, enter_s[i]};
    end
    ev_sum_s = {1'b0, gate_events_q} + {12'd0, n_enter_s};
    if (stat_clr) begin
      gate_events_d = 16'd0;
    end else if (ev_sum_s[16]) begin
      gate_events_d = 16'hFFFF;
    end else begin
      gate_events_d = ev_sum_s[15:0];
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_DOM; i++) begin
        state_q[i] <= ST_RUN;
        icnt_q[i]  <= 8'd0;
        wcnt_q[i]  <= 4'd0;
      end
      clk_en_q      <= {N_DOM{1'b1}};
      rdy_q         <= {N_DOM{1'b1}};
      gated_q       <= {N_DOM{1'b0}};
      gate_events_q <= 16'd0;
    end else begin
      for (int i = 0; i < N_DOM; i++) begin
        state_q[i] <= state_d[i];
        icnt_q[i]  <= icnt_d[i];
        wcnt_q[i]  <= wcnt_d[i];
      end
      clk_en_q      <= clk_en_d;
      rdy_q         <= rdy_d;
      gated_q       <= gated_d;
      gate_events_q <= gate_events_d;
    end
  end

  assign clk_en      = clk_en_q;
  assign rdy         = rdy_q;
  assign gated       = gated_q;
  assign gate_events = gate_events_q;

endmodule
